// File: rtl/luma_reg_access.sv
// Byte-wide field access sequencer for the 16 x 18-bit colour register RAM (port A).
// Optional build macro LUMA_REG_AUTOINC_EN: auto-incrementing index pointer replaces req_idx.
module luma_reg_access #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              req_we,
  input  logic [1:0]        req_sel,
  input  logic [ADDR_W-1:0] req_idx,
  input  logic [7:0]        req_data,
  output logic              busy,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              req_drop,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [1:0] SEL_LUMA  = 2'd0;
  localparam logic [1:0] SEL_PHASE = 2'd1;
  localparam logic [1:0] SEL_AMP   = 2'd2;
  localparam logic [1:0] SEL_PTR   = 2'd3;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, WRITE} state_t;

  state_t      state;
  logic        we_q;
  logic [1:0]  sel_q;
  logic [7:0]  data_q;

  logic [DATA_W-1:0] merged_c;
  logic [7:0]        field_c;

`ifdef LUMA_REG_AUTOINC_EN
  logic [ADDR_W-1:0] ptr;
  logic              unused_idx;
  assign unused_idx = ^req_idx;
`endif

  // Field merge for the write path and field extraction for the read path
  always_comb begin
    merged_c = ram_dout;
    field_c  = 8'h00;
    case (sel_q)
      SEL_LUMA: begin
        merged_c[17:12] = data_q[5:0];
        field_c         = {2'b00, ram_dout[17:12]};
      end
      SEL_PHASE: begin
        merged_c[11:4] = data_q;
        field_c        = ram_dout[11:4];
      end
      SEL_AMP: begin
        merged_c[3:0] = data_q[3:0];
        field_c       = {4'b0000, ram_dout[3:0]};
      end
      default: begin
`ifdef LUMA_REG_AUTOINC_EN
        field_c = 8'(ptr);
`else
        field_c = 8'h00;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      sel_q    <= 2'd0;
      data_q   <= 8'h00;
      busy     <= 1'b0;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
      req_drop <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
`ifdef LUMA_REG_AUTOINC_EN
      ptr      <= '0;
`endif
    end else begin
      rd_valid <= 1'b0;
      ram_we   <= 1'b0;
      req_drop <= req && busy;
      case (state)
        IDLE: begin
          if (req) begin
            we_q   <= req_we;
            sel_q  <= req_sel;
            data_q <= req_data;
`ifdef LUMA_REG_AUTOINC_EN
            ram_addr <= ptr;
`else
            ram_addr <= req_idx;
`endif
            busy  <= 1'b1;
            state <= ADDR;
          end
        end
        ADDR: state <= DATA;
        DATA: begin
          if (!we_q) begin
            rd_data  <= field_c;
            rd_valid <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
`ifdef LUMA_REG_AUTOINC_EN
            if (sel_q == SEL_AMP) ptr <= ptr + ADDR_W'(1);
`endif
          end else if (sel_q == SEL_PTR) begin
            busy  <= 1'b0;
            state <= IDLE;
`ifdef LUMA_REG_AUTOINC_EN
            ptr <= data_q[ADDR_W-1:0];
`endif
          end else begin
            ram_din <= merged_c;
            ram_we  <= 1'b1;
            state   <= WRITE;
          end
        end
        WRITE: begin
          busy  <= 1'b0;
          state <= IDLE;
`ifdef LUMA_REG_AUTOINC_EN
          if (sel_q == SEL_AMP) ptr <= ptr + ADDR_W'(1);
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_luma_reg_access.sv
// Directed self-checking bench for luma_reg_access with a registered-read RAM model on port A.
module tb_luma_reg_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, req_we;
  logic [1:0]  req_sel;
  logic [3:0]  req_idx;
  logic [7:0]  req_data;
  logic        busy, rd_valid, req_drop, ram_we;
  logic [7:0]  rd_data;
  logic [3:0]  ram_addr;
  logic [17:0] ram_din, ram_dout;

  logic        pre_we;
  logic [3:0]  pre_idx;
  logic [17:0] pre_val;
  logic [17:0] mem [16];

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  luma_reg_access #(.ADDR_W(4), .DATA_W(18)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_sel(req_sel),
    .req_idx(req_idx), .req_data(req_data), .busy(busy), .rd_data(rd_data),
    .rd_valid(rd_valid), .req_drop(req_drop), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // RAM model: registered read, write on ram_we; pre_we is a bench-only preload port
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_val;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [17:0] val);
    step();
    pre_we = 1'b1; pre_idx = idx; pre_val = val;
    step();
    pre_we = 1'b0;
  endtask

  // One full access from cycle 0 through cycle 4 with per-cycle checks
  task automatic access(input string tag, input logic we, input logic [1:0] sel,
                        input logic [3:0] idx, input logic [7:0] data,
                        input logic [3:0] midx, input logic [17:0] exp_word,
                        input logic [7:0] exp_rd);
    step();
    req = 1'b1; req_we = we; req_sel = sel; req_idx = idx; req_data = data;
    chk({tag, ".c0_busy"}, 32'(busy), 32'd0);
    step();
    req = 1'b0;
    chk({tag, ".c1_busy"}, 32'(busy), 32'd1);
    chk({tag, ".c1_addr"}, 32'(ram_addr), 32'(midx));
    step();
    chk({tag, ".c2_we"}, 32'(ram_we), 32'd0);
    chk({tag, ".c2_valid"}, 32'(rd_valid), 32'd0);
    step();
    chk({tag, ".c3_excl"}, 32'(ram_we & rd_valid), 32'd0);
    if (!we) begin
      chk({tag, ".c3_valid"}, 32'(rd_valid), 32'd1);
      chk({tag, ".c3_rdata"}, 32'(rd_data), 32'(exp_rd));
      chk({tag, ".c3_busy"}, 32'(busy), 32'd0);
    end else if (sel != 2'd3) begin
      chk({tag, ".c3_we"}, 32'(ram_we), 32'd1);
      chk({tag, ".c3_din"}, 32'(ram_din), 32'(exp_word));
      chk({tag, ".c3_busy"}, 32'(busy), 32'd1);
    end else begin
      chk({tag, ".c3_we"}, 32'(ram_we), 32'd0);
      chk({tag, ".c3_busy"}, 32'(busy), 32'd0);
    end
    step();
    chk({tag, ".c4_we"}, 32'(ram_we), 32'd0);
    chk({tag, ".c4_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, ".c4_busy"}, 32'(busy), 32'd0);
    chk({tag, ".c4_mem"}, 32'(mem[midx]), 32'(exp_word));
  endtask

  initial begin
    logic [7:0] busy_exp, drop_exp, valid_exp;
    rst = 1'b1; req = 1'b0; req_we = 1'b0; req_sel = 2'd0; req_idx = 4'd0;
    req_data = 8'h00; pre_we = 1'b0; pre_idx = 4'd0; pre_val = 18'h0;
    step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_drop", 32'(req_drop), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_din", 32'(ram_din), 32'd0);
    chk("rst_rdata", 32'(rd_data), 32'd0);
    rst = 1'b0;

`ifdef LUMA_REG_AUTOINC_EN
    preload(4'd15, 18'h0);
    preload(4'd0, {6'h05, 8'h66, 4'h7});
    access("ptr_load", 1'b1, 2'd3, 4'd3, 8'h0F, 4'd0, {6'h05, 8'h66, 4'h7}, 8'h00);
    access("ai_luma", 1'b1, 2'd0, 4'd3, 8'h11, 4'd15, 18'h11000, 8'h00);
    access("ai_phase", 1'b1, 2'd1, 4'd3, 8'h22, 4'd15, 18'h11220, 8'h00);
    access("ai_amp", 1'b1, 2'd2, 4'd3, 8'h03, 4'd15, 18'h11223, 8'h00);
    access("ai_ptr_rd", 1'b0, 2'd3, 4'd3, 8'h00, 4'd0, {6'h05, 8'h66, 4'h7}, 8'h00);
    access("ai_wrap_rd", 1'b0, 2'd0, 4'd3, 8'h00, 4'd0, {6'h05, 8'h66, 4'h7}, 8'h05);
`else
    // Field reads
    preload(4'd5, {6'h3A, 8'hA5, 4'hC});
    access("rd_luma", 1'b0, 2'd0, 4'd5, 8'h00, 4'd5, {6'h3A, 8'hA5, 4'hC}, 8'h3A);
    access("rd_phase", 1'b0, 2'd1, 4'd5, 8'h00, 4'd5, {6'h3A, 8'hA5, 4'hC}, 8'hA5);
    access("rd_amp", 1'b0, 2'd2, 4'd5, 8'h00, 4'd5, {6'h3A, 8'hA5, 4'hC}, 8'h0C);
    access("rd_sel3", 1'b0, 2'd3, 4'd5, 8'h00, 4'd5, {6'h3A, 8'hA5, 4'hC}, 8'h00);

    // Read-modify-write merges
    preload(4'd2, {6'h2A, 8'h5B, 4'h7});
    access("wr_phase", 1'b1, 2'd1, 4'd2, 8'hE1, 4'd2, {6'h2A, 8'hE1, 4'h7}, 8'h00);
    access("wr_luma", 1'b1, 2'd0, 4'd2, 8'hFF, 4'd2, {6'h3F, 8'hE1, 4'h7}, 8'h00);
    access("wr_amp", 1'b1, 2'd2, 4'd2, 8'hF9, 4'd2, {6'h3F, 8'hE1, 4'h9}, 8'h00);
    access("wr_sel3", 1'b1, 2'd3, 4'd2, 8'h55, 4'd2, {6'h3F, 8'hE1, 4'h9}, 8'h00);

    // req held 6 cycles: accepts in cycles 0 and 3, drops echoed one cycle later
    busy_exp  = 8'b0011_0110;
    drop_exp  = 8'b0110_1100;
    valid_exp = 8'b0100_1000;
    req_we = 1'b0; req_sel = 2'd0; req_idx = 4'd5;
    for (int c = 0; c < 8; c++) begin
      step();
      req = (c < 6);
      chk($sformatf("hold.c%0d_busy", c), 32'(busy), 32'(busy_exp[c]));
      chk($sformatf("hold.c%0d_drop", c), 32'(req_drop), 32'(drop_exp[c]));
      chk($sformatf("hold.c%0d_valid", c), 32'(rd_valid), 32'(valid_exp[c]));
      if (valid_exp[c]) chk($sformatf("hold.c%0d_rdata", c), 32'(rd_data), 32'h3A);
    end

    // Reset while the write is pending: no RAM update
    step();
    req = 1'b1; req_we = 1'b1; req_sel = 2'd2; req_idx = 4'd2; req_data = 8'h05;
    step(); req = 1'b0;
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    chk("rstw_we", 32'(ram_we), 32'd0);
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_valid", 32'(rd_valid), 32'd0);
    step();
    chk("rstw_we2", 32'(ram_we), 32'd0);
    chk("rstw_mem", 32'(mem[2]), 32'({6'h3F, 8'hE1, 4'h9}));

    // Reset while a read is pending: rd_valid cancelled
    step();
    req = 1'b1; req_we = 1'b0; req_sel = 2'd0; req_idx = 4'd5;
    step(); req = 1'b0;
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    chk("rstr_valid", 32'(rd_valid), 32'd0);
    chk("rstr_busy", 32'(busy), 32'd0);
    access("post_rst", 1'b0, 2'd2, 4'd2, 8'h00, 4'd2, {6'h3F, 8'hE1, 4'h9}, 8'h09);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
